// File: rtl/fft_pkg.sv
// Shared FFT definitions: twiddle-sequencer state type and default stage geometry
// used by the stage providers.
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } tf_seq_state_t;

  localparam int FFT_FLOAT_LEN  = 32;
  localparam int FFT_FRAME_LOG2 = 13;
  localparam int FFT_TF_LOG2    = 5;

endpackage

// File: rtl/tf_addr_gen.sv
// Twiddle ROM address generator: optional hold prescaler followed by a
// naturally wrapping address register.
module tf_addr_gen
  import fft_pkg::*;
#(
  parameter int addr_len  = FFT_TF_LOG2,
  parameter int hold_log2 = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                step,
  output logic [addr_len-1:0] tf_addr
);

  localparam logic [addr_len-1:0] ADDR_ONE = 1;

  logic advance;

  generate
    if (hold_log2 == 0) begin : g_no_hold
      assign advance = step;
    end else begin : g_hold
      localparam logic [hold_log2-1:0] HOLD_ONE = 1;
      logic [hold_log2-1:0] hold_cnt;

      always_ff @(posedge clk) begin
        if (rst || clear) begin
          hold_cnt <= '0;
        end else if (step) begin
          hold_cnt <= hold_cnt + HOLD_ONE;
        end
      end

      // The address moves on the sample that wraps the hold counter.
      assign advance = step && (&hold_cnt);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      tf_addr <= '0;
    end else if (advance) begin
      tf_addr <= tf_addr + ADDR_ONE;
    end
  end

endmodule

// File: rtl/tf_sequencer.sv
// Frame controller for one FFT stage's twiddle ROM (enable, address, valid, status).
// Optional macro TF_SEQ_OVERRUN_EN adds a sticky overrun flag output.
module tf_sequencer
  import fft_pkg::*;
#(
  parameter int float_len        = FFT_FLOAT_LEN,
  parameter int bram_addr_len    = FFT_FRAME_LOG2,
  parameter int stageNum         = 6,
  parameter int bram_tf_addr_len = FFT_TF_LOG2,
  parameter int tf_hold_log2     = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        in_valid,
  output logic                        tf_en,
  output logic [bram_tf_addr_len-1:0] tf_addr,
  output logic                        tf_valid,
  output logic                        busy,
  output logic                        frame_done,
  output logic [7:0]                  stage_id
`ifdef TF_SEQ_OVERRUN_EN
  ,
  output logic                        overrun
`endif
);

  localparam logic [bram_addr_len-1:0] SAMPLE_ONE = 1;

  generate
    if (float_len < 1) begin : g_bad_float_len
      $error("tf_sequencer: float_len must be positive");
    end
  endgenerate

  tf_seq_state_t            state;
  tf_seq_state_t            state_next;
  logic [bram_addr_len-1:0] sample_cnt;
  logic                     clear;

  assign stage_id = 8'(stageNum);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A start seen in FLUSH re-enters RUN directly so frames can run back to back.
  always_comb begin
    state_next = state;
    tf_en      = 1'b0;
    busy       = 1'b0;
    clear      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          clear      = 1'b1;
        end
      end
      RUN: begin
        busy  = 1'b1;
        tf_en = in_valid;
        if (in_valid && (&sample_cnt)) begin
          state_next = FLUSH;
        end
      end
      FLUSH: begin
        busy = 1'b1;
        if (start) begin
          state_next = RUN;
          clear      = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sample_cnt <= '0;
    end else if (tf_en) begin
      sample_cnt <= sample_cnt + SAMPLE_ONE;
    end
  end

  // tf_valid tracks the ROM's single-cycle read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      tf_valid   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      tf_valid   <= tf_en;
      frame_done <= (state_next == FLUSH);
    end
  end

  tf_addr_gen #(
    .addr_len (bram_tf_addr_len),
    .hold_log2(tf_hold_log2)
  ) u_addr_gen (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear),
    .step   (tf_en),
    .tf_addr(tf_addr)
  );

`ifdef TF_SEQ_OVERRUN_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if ((state == RUN && start) || (state == IDLE && in_valid)) begin
      overrun <= 1'b1;
    end
  end
`endif

endmodule
